// File: rtl/icache_refill_bridge.sv
// Bridges 128-bit instruction-cache line reads/writes onto a 32-bit word bus, one beat at a time.
// Optional read timeout enabled by defining ICACHE_REFILL_TIMEOUT_EN.
module icache_refill_bridge #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  i_m_addr,
   input  logic [15:0]  i_m_byte_en,
   input  logic [127:0] i_m_writedata,
   input  logic         i_m_read,
   input  logic         i_m_write,
   output logic [127:0] o_m_readdata,
   output logic         o_m_readdata_valid,
   output logic         o_m_waitrequest,
   output logic [31:0]  o_bus_addr,
   output logic         o_bus_req,
   output logic         o_bus_we,
   output logic [3:0]   o_bus_be,
   output logic [31:0]  o_bus_wdata,
   input  logic         i_bus_gnt,
   input  logic [31:0]  i_bus_rdata,
   input  logic         i_bus_rvalid,
   output logic         o_timeout_err
);

   typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_DONE, WR_REQ} state_t;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } beat_sel_t;

   // Lowest beat at or above 'from' whose byte enables are not all zero.
   function automatic beat_sel_t first_beat(input logic [15:0] be, input logic [2:0] from);
      beat_sel_t sel;
      sel = '0;
      for (int i = 3; i >= 0; i--) begin
         if ((3'(i) >= from) && (|be[4*i +: 4])) begin
            sel.found = 1'b1;
            sel.idx   = 2'(i);
         end
      end
      return sel;
   endfunction

   state_t          state, state_next;
   logic [1:0]      k, k_next;
   logic [27:0]     addr_q;
   logic [3:0][3:0] be_q;
   logic [3:0][31:0] wdata_q;
   logic [3:0][31:0] line_buf;

   logic            capture_rd, capture_wr;
   logic            beat_done, tmo_fire, tmo_expired;
   logic [31:0]     beat_data;
   beat_sel_t       sel;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state <= IDLE;
         k     <= '0;
      end else begin
         state <= state_next;
         k     <= k_next;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_next         = state;
      k_next             = k;
      capture_rd         = 1'b0;
      capture_wr         = 1'b0;
      beat_done          = 1'b0;
      tmo_fire           = 1'b0;
      beat_data          = i_bus_rdata;
      sel                = '0;
      o_bus_req          = 1'b0;
      o_bus_we           = 1'b0;
      o_bus_be           = 4'h0;
      o_bus_addr         = 32'h0;
      o_bus_wdata        = 32'h0;
      o_m_waitrequest    = (state != IDLE);
      o_m_readdata_valid = 1'b0;

      case (state)
         IDLE: begin
            if (i_m_read) begin
               capture_rd = 1'b1;
               k_next     = 2'd0;
               state_next = RD_REQ;
            end else if (i_m_write) begin
               sel = first_beat(i_m_byte_en, 3'd0);
               // An all-zero enable mask is accepted but produces no bus traffic.
               if (sel.found) begin
                  capture_wr = 1'b1;
                  k_next     = sel.idx;
                  state_next = WR_REQ;
               end
            end
         end

         RD_REQ: begin
            o_bus_req  = 1'b1;
            o_bus_be   = 4'hF;
            o_bus_addr = {addr_q, k, 2'b00};
            if (i_bus_gnt) state_next = RD_WAIT;
         end

         RD_WAIT: begin
            if (i_bus_rvalid) begin
               beat_done = 1'b1;
            end else if (tmo_expired) begin
               beat_done = 1'b1;
               beat_data = 32'h0;
               tmo_fire  = 1'b1;
            end
            if (beat_done) begin
               if (k == 2'd3) begin
                  state_next = RD_DONE;
               end else begin
                  k_next     = k + 2'd1;
                  state_next = RD_REQ;
               end
            end
         end

         RD_DONE: begin
            o_m_readdata_valid = 1'b1;
            state_next         = IDLE;
         end

         WR_REQ: begin
            o_bus_req   = 1'b1;
            o_bus_we    = 1'b1;
            o_bus_be    = be_q[k];
            o_bus_wdata = wdata_q[k];
            o_bus_addr  = {addr_q, k, 2'b00};
            if (i_bus_gnt) begin
               sel = first_beat(be_q, {1'b0, k} + 3'd1);
               if (sel.found) begin
                  k_next = sel.idx;
               end else begin
                  k_next     = 2'd0;
                  state_next = IDLE;
               end
            end
         end

         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q       <= '0;
         be_q         <= '0;
         wdata_q      <= '0;
         line_buf     <= '0;
         o_m_readdata <= '0;
      end else begin
         if (capture_rd || capture_wr) addr_q <= i_m_addr[31:4];
         if (capture_wr) begin
            be_q    <= i_m_byte_en;
            wdata_q <= i_m_writedata;
         end
         // The visible line only changes when the final beat lands, so it holds across reads in flight.
         if (beat_done) begin
            if (k == 2'd3) o_m_readdata <= {beat_data, line_buf[2], line_buf[1], line_buf[0]};
            else           line_buf[k]  <= beat_data;
         end
      end
   end

`ifdef ICACHE_REFILL_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] tmo_cnt;
   logic       tmo_err_q;

   assign tmo_expired   = (state == RD_WAIT) && (tmo_cnt == TMO_LAST);
   assign o_timeout_err = tmo_err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         tmo_cnt   <= '0;
         tmo_err_q <= 1'b0;
      end else begin
         if ((state != RD_WAIT) || beat_done) tmo_cnt <= '0;
         else                                 tmo_cnt <= tmo_cnt + 8'd1;
         if (tmo_fire) tmo_err_q <= 1'b1;
      end
   end
`else
   assign tmo_expired   = 1'b0;
   assign o_timeout_err = 1'b0;
`endif

   logic unused_ok;
   assign unused_ok = &{1'b0, i_m_addr[3:0], line_buf[3], tmo_fire};

endmodule

// File: tb/tb_icache_refill_bridge.sv
// Directed + randomized bench for icache_refill_bridge; expected bus beats and lines come from a
// line-level model (per-word enables, beat address arithmetic), not from the bridge's FSM.
module tb_icache_refill_bridge;

`ifdef ICACHE_REFILL_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 255;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  i_m_addr;
   logic [15:0]  i_m_byte_en;
   logic [127:0] i_m_writedata;
   logic         i_m_read, i_m_write;
   logic [127:0] o_m_readdata;
   logic         o_m_readdata_valid, o_m_waitrequest;
   logic [31:0]  o_bus_addr;
   logic         o_bus_req, o_bus_we;
   logic [3:0]   o_bus_be;
   logic [31:0]  o_bus_wdata;
   logic         i_bus_gnt;
   logic [31:0]  i_bus_rdata;
   logic         i_bus_rvalid;
   logic         o_timeout_err;

   icache_refill_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst),
      .i_m_addr(i_m_addr), .i_m_byte_en(i_m_byte_en), .i_m_writedata(i_m_writedata),
      .i_m_read(i_m_read), .i_m_write(i_m_write),
      .o_m_readdata(o_m_readdata), .o_m_readdata_valid(o_m_readdata_valid),
      .o_m_waitrequest(o_m_waitrequest),
      .o_bus_addr(o_bus_addr), .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
      .o_bus_be(o_bus_be), .o_bus_wdata(o_bus_wdata),
      .i_bus_gnt(i_bus_gnt), .i_bus_rdata(i_bus_rdata), .i_bus_rvalid(i_bus_rvalid),
      .o_timeout_err(o_timeout_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   longint cyc = 0;
   int vcount = 0;
   logic [127:0] last_line = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (o_m_readdata_valid) vcount <= vcount + 1;
   end

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } wr_beat_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (!o_bus_req && n < 20) begin
         tick();
         n++;
      end
   endtask

   // Full line read with an in-bench bus slave. slow_beat stalls gnt for slow_cycles (with a stray
   // rvalid); drop_beat never returns rvalid, relying on the timeout.
   task automatic run_read(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input int slow_beat,
                           input int slow_cycles, input bit also_write, input int drop_beat);
      logic [31:0] w[4];
      logic [31:0] ea;
      logic [127:0] exp_line;
      longint t0;
      int n;
      int extra;
      w = '{w0, w1, w2, w3};
      extra = 0;
      check("rd_accept_ready", o_m_waitrequest, 1'b0);
      i_m_addr = a;
      i_m_read = 1'b1;
      if (also_write) begin
         i_m_write     = 1'b1;
         i_m_byte_en   = 16'hFFFF;
         i_m_writedata = {$urandom, $urandom, $urandom, $urandom};
      end
      t0 = cyc;
      tick();
      i_m_read  = 1'b0;
      i_m_write = 1'b0;
      i_m_addr  = $urandom;
      for (int b = 0; b < 4; b++) begin
         ea = {a[31:4], 2'(b), 2'b00};
         wait_req();
         check("rd_req", o_bus_req, 1'b1);
         check("rd_addr", o_bus_addr, ea);
         check("rd_we", o_bus_we, 1'b0);
         check("rd_be", o_bus_be, 4'hF);
         if (b == slow_beat) begin
            for (int i = 0; i < slow_cycles; i++) begin
               i_bus_rvalid = (i == 1);
               i_bus_rdata  = 32'hDEAD_0000 | 32'(i);
               tick();
               check("rd_hold_req", o_bus_req, 1'b1);
               check("rd_hold_addr", o_bus_addr, ea);
            end
            extra = slow_cycles;
         end
         i_bus_rvalid = 1'b0;
         i_bus_gnt    = 1'b1;
         tick();
         i_bus_gnt = 1'b0;
         check("rd_wait_noreq", o_bus_req, 1'b0);
         if (b == drop_beat) begin
            w[b] = 32'h0;
            n = 0;
            while (!o_bus_req && !o_m_readdata_valid && n < 300) begin
               tick();
               n++;
            end
            check("tmo_cycles", 128'(n), 128'(TMO));
            check("tmo_flag", o_timeout_err, 1'b1);
         end else begin
            i_bus_rdata  = w[b];
            i_bus_rvalid = 1'b1;
            i_bus_gnt    = (b == slow_beat);
            tick();
            i_bus_rvalid = 1'b0;
            i_bus_gnt    = 1'b0;
            i_bus_rdata  = $urandom;
         end
      end
      exp_line = {w[3], w[2], w[1], w[0]};
      check("rd_valid", o_m_readdata_valid, 1'b1);
      check("rd_line", o_m_readdata, exp_line);
      if (drop_beat < 0) check("rd_latency", 128'(cyc - t0), 128'(9 + extra));
      tick();
      check("rd_valid_pulse", o_m_readdata_valid, 1'b0);
      check("rd_idle", o_m_waitrequest, 1'b0);
      check("rd_line_hold", o_m_readdata, exp_line);
      last_line = exp_line;
   endtask

   task automatic run_write(input logic [31:0] a, input logic [15:0] be, input logic [127:0] data);
      wr_beat_t q[$];
      wr_beat_t e;
      int v0;
      int dly;
      for (int b = 0; b < 4; b++) begin
         if (be[4*b +: 4] != 4'h0) begin
            e.addr = {a[31:4], 2'(b), 2'b00};
            e.be   = be[4*b +: 4];
            e.data = data[32*b +: 32];
            q.push_back(e);
         end
      end
      v0 = vcount;
      check("wr_accept_ready", o_m_waitrequest, 1'b0);
      i_m_addr      = a;
      i_m_byte_en   = be;
      i_m_writedata = data;
      i_m_write     = 1'b1;
      tick();
      i_m_write     = 1'b0;
      i_m_addr      = $urandom;
      i_m_byte_en   = 16'($urandom);
      i_m_writedata = {$urandom, $urandom, $urandom, $urandom};
      foreach (q[i]) begin
         wait_req();
         check("wr_req", o_bus_req, 1'b1);
         check("wr_we", o_bus_we, 1'b1);
         check("wr_addr", o_bus_addr, q[i].addr);
         check("wr_be", o_bus_be, q[i].be);
         check("wr_data", o_bus_wdata, q[i].data);
         dly = $urandom_range(0, 2);
         repeat (dly) begin
            tick();
            check("wr_hold_addr", o_bus_addr, q[i].addr);
         end
         i_bus_gnt = 1'b1;
         tick();
         i_bus_gnt = 1'b0;
      end
      check("wr_done_idle", o_m_waitrequest, 1'b0);
      check("wr_done_noreq", o_bus_req, 1'b0);
      tick();
      check("wr_no_valid", 128'(vcount), 128'(v0));
      check("wr_line_hold", o_m_readdata, last_line);
   endtask

   initial begin
      logic [15:0] be;
      logic [31:0] w[4];
      rst = 1'b1;
      i_m_addr = '0; i_m_byte_en = '0; i_m_writedata = '0;
      i_m_read = 1'b0; i_m_write = 1'b0;
      i_bus_gnt = 1'b0; i_bus_rdata = '0; i_bus_rvalid = 1'b0;
      tick();
      tick();
      check("rst_wait", o_m_waitrequest, 1'b0);
      check("rst_req", o_bus_req, 1'b0);
      check("rst_we", o_bus_we, 1'b0);
      check("rst_be", o_bus_be, 4'h0);
      check("rst_addr", o_bus_addr, 32'h0);
      check("rst_wdata", o_bus_wdata, 32'h0);
      check("rst_line", o_m_readdata, 128'h0);
      check("rst_valid", o_m_readdata_valid, 1'b0);
      check("rst_tmo", o_timeout_err, 1'b0);
      rst = 1'b0;
      tick();

      run_read(32'h0000_1234, 32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, 0, 1'b0, -1);
      run_write(32'h0000_2000, 16'h0F0F, {$urandom, $urandom, $urandom, $urandom});
      run_read($urandom, $urandom, $urandom, $urandom, $urandom, -1, 0, 1'b1, -1);
      run_read($urandom, $urandom, $urandom, $urandom, $urandom, 1, 5, 1'b0, -1);
      run_write($urandom, 16'h0000, {$urandom, $urandom, $urandom, $urandom});
      run_write($urandom, 16'hF001, {$urandom, $urandom, $urandom, $urandom});

      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(0, 1) == 1) begin
            run_read($urandom, $urandom, $urandom, $urandom, $urandom,
                     int'($urandom_range(0, 4)) - 1, int'($urandom_range(2, 4)), 1'b0, -1);
         end else begin
            be = 16'($urandom);
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 2) == 0) be[4*b +: 4] = 4'h0;
            run_write($urandom, be, {$urandom, $urandom, $urandom, $urandom});
         end
      end

      // Reset while waiting for beat 2 of a read; a late response must be dropped.
      i_m_addr = 32'h0000_5670;
      i_m_read = 1'b1;
      tick();
      i_m_read = 1'b0;
      for (int b = 0; b < 2; b++) begin
         i_bus_gnt = 1'b1;
         tick();
         i_bus_gnt = 1'b0;
         i_bus_rvalid = 1'b1;
         i_bus_rdata = $urandom;
         tick();
         i_bus_rvalid = 1'b0;
      end
      check("mid_addr_b2", o_bus_addr, 32'h0000_5678);
      i_bus_gnt = 1'b1;
      tick();
      i_bus_gnt = 1'b0;
      check("mid_in_wait", o_m_waitrequest, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_wait", o_m_waitrequest, 1'b0);
      check("mrst_req", o_bus_req, 1'b0);
      check("mrst_addr", o_bus_addr, 32'h0);
      check("mrst_be", o_bus_be, 4'h0);
      check("mrst_line", o_m_readdata, 128'h0);
      check("mrst_valid", o_m_readdata_valid, 1'b0);
      i_bus_rvalid = 1'b1;
      i_bus_rdata  = 32'hBAD0_BAD0;
      tick();
      i_bus_rvalid = 1'b0;
      tick();
      check("late_rvalid_line", o_m_readdata, 128'h0);
      check("late_rvalid_idle", o_m_waitrequest, 1'b0);
      last_line = '0;
      run_read($urandom, $urandom, $urandom, $urandom, $urandom, -1, 0, 1'b0, -1);

`ifdef ICACHE_REFILL_TIMEOUT_EN
      for (int b = 0; b < 4; b++) w[b] = $urandom;
      run_read($urandom, w[0], w[1], w[2], w[3], -1, 0, 1'b0, 0);
      run_read($urandom, $urandom, $urandom, $urandom, $urandom, -1, 0, 1'b0, -1);
      check("tmo_sticky", o_timeout_err, 1'b1);
`else
      w = '{default: 32'h0};
      check("tmo_const0", o_timeout_err, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/icache_refill_bridge.md
ICACHE_REFILL_BRIDGE -- requirements
Module: icache_refill_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: number of cycles waited for i_bus_rvalid before a read beat is abandoned (1..255).
REQ-002 SHALL have port clk  in  1  single clock; all logic on the rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_m_addr  in  32  cache line byte address from the instruction cache memory port; bits [3:0] ignored.
REQ-005 SHALL have port i_m_byte_en  in  16  line byte enables; bits [4k+3:4k] belong to word k.
REQ-006 SHALL have port i_m_writedata  in  128  line write data; word k is bits [32k+31:32k].
REQ-007 SHALL have port i_m_read  in  1  line read request.
REQ-008 SHALL have port i_m_write  in  1  line write request.
REQ-009 SHALL have port o_m_readdata  out  128  assembled line.
REQ-010 SHALL have port o_m_readdata_valid  out  1  one-cycle pulse; o_m_readdata valid.
REQ-011 SHALL have port o_m_waitrequest  out  1  bridge busy; cache command not accepted.
REQ-012 SHALL have ports o_bus_addr out 32, o_bus_req out 1, o_bus_we out 1, o_bus_be out 4, o_bus_wdata out 32: word bus request, address, write flag, byte enables, write data.
REQ-013 SHALL have ports i_bus_gnt in 1 (request accepted this cycle), i_bus_rdata in 32, i_bus_rvalid in 1 (read data valid).
REQ-014 SHALL have port o_timeout_err  out  1  sticky read-timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, RD_DONE, WR_REQ.
REQ-016 o_m_waitrequest SHALL be 0 only in IDLE.
REQ-017 In IDLE with i_m_read=1, the FSM SHALL capture the line address, clear beat counter k to 0, and go to RD_REQ; i_m_read takes priority over i_m_write.
REQ-018 In IDLE with only i_m_write=1, the FSM SHALL capture the address, byte enables and data, and go to WR_REQ at the first beat with nonzero byte enables; if all 16 enables are 0, it SHALL stay in IDLE and issue no bus traffic.
REQ-019 Beat address SHALL be {addr[31:4], k[1:0], 2'b00}; k counts 0..3 and never wraps within a command.
REQ-020 RD_REQ SHALL hold o_bus_req=1, o_bus_we=0, o_bus_be=4'hF until i_bus_gnt=1, then go to RD_WAIT; at most one read outstanding.
REQ-021 RD_WAIT SHALL store i_bus_rdata into word k on i_bus_rvalid=1, then go to RD_REQ with k+1, or to RD_DONE if k=3.
REQ-022 RD_DONE SHALL assert o_m_readdata_valid for exactly one cycle and return to IDLE; o_m_readdata SHALL hold its value until the next read completes.
REQ-023 WR_REQ SHALL drive o_bus_req=1, o_bus_we=1, o_bus_be=byte_en word k, o_bus_wdata=data word k; on i_bus_gnt it SHALL advance to the next beat with nonzero enables, or to IDLE after the last such beat; a write SHALL never pulse o_m_readdata_valid.
REQ-024 i_bus_rvalid outside RD_WAIT SHALL be ignored; i_bus_gnt while o_bus_req=0 SHALL be ignored.
REQ-025 o_bus_req SHALL be 0 in IDLE, RD_WAIT and RD_DONE.
REQ-026 Latency: with i_bus_gnt=1 on the first request cycle and i_bus_rvalid one cycle after gnt, o_m_readdata_valid SHALL rise 9 cycles after the accepting IDLE cycle.

Reset
REQ-027 rst=1 SHALL force IDLE, k=0, o_bus_req=0, o_bus_we=0, o_bus_be=0, o_bus_addr=0, o_bus_wdata=0, o_m_readdata=0, o_m_readdata_valid=0, o_timeout_err=0, and the timeout counter to 0.
REQ-028 Reset mid-command SHALL abandon the command; responses arriving after reset SHALL be ignored.

Configuration
REQ-029 With macro ICACHE_REFILL_TIMEOUT_EN defined, RD_WAIT SHALL count cycles from entry; after TIMEOUT_CYCLES cycles without i_bus_rvalid it SHALL write 32'h0 into word k, set o_timeout_err=1 (sticky until rst), and advance as if i_bus_rvalid had arrived.
REQ-030 Without ICACHE_REFILL_TIMEOUT_EN, RD_WAIT SHALL wait indefinitely, and o_timeout_err SHALL be constant 0.

Verification
REQ-031 Read 0x0000_1234, gnt immediate, rvalid 1 cycle later with data 0xA0..0xA3 -> bus addresses 0x1230, 0x1234, 0x1238, 0x123C; o_m_readdata=0x000000A3_000000A2_000000A1_000000A0; valid pulse 9 cycles after accept.
REQ-032 Write 0x2000 with byte_en=16'h0F0F -> exactly two bus writes, to 0x2000 and 0x2008, each with be=4'hF; no readdata_valid; waitrequest is low on the cycle after the second gnt.
REQ-033 i_m_read and i_m_write both high in IDLE -> read performed; no bus write issued.
REQ-034 gnt withheld 5 cycles on beat 1, plus a spurious rvalid in RD_REQ -> o_bus_req held steady, addr 0x..4 stable, spurious data discarded, correct line returned.
REQ-035 rst pulsed while in RD_WAIT for beat 2 -> next cycle IDLE, all outputs 0, and a late rvalid does not alter o_m_readdata.
REQ-036 With ICACHE_REFILL_TIMEOUT_EN and TIMEOUT_CYCLES=8, no rvalid on beat 0 -> word 0 = 0, o_timeout_err=1 and stays 1, remaining beats complete normally.
